// File: rtl/rx_if.sv
// Serial-receive bus: line, oversample clock and read handshake bundled for the rx block.
// master = upstream/consumer side, slave = the receiver itself.
interface rx_if #(
    parameter int WIDTH_DATA = 8
);
    logic                  clk_rx;
    logic                  i_rx;
    logic                  i_re;
    logic [WIDTH_DATA-1:0] o_data;
    logic                  o_rdy;
    logic                  o_ferr;
    logic                  o_ovr;

    modport master (
        output clk_rx, i_rx, i_re,
        input  o_data, o_rdy, o_ferr, o_ovr
    );

    modport slave (
        input  clk_rx, i_rx, i_re,
        output o_data, o_rdy, o_ferr, o_ovr
    );
endinterface

// File: rtl/rx.sv
// UART receiver: oversampled start validation, LSB-first data, NB_STOP stop checks, ready/read handshake.
// Optional RX_MAJORITY_EN: each sample is the 2-of-3 majority of the last three ticks.
module rx #(
    parameter int WIDTH_DATA = 8,
    parameter int NB_STOP    = 2,
    parameter int OVERSAMPLE = 16
) (
    input logic i_clk,
    input logic i_rst,
    rx_if.slave bus
);
    localparam int CW   = $clog2(OVERSAMPLE);
    localparam int BMAX = (WIDTH_DATA > NB_STOP) ? WIDTH_DATA : NB_STOP;
    localparam int BW   = (BMAX > 1) ? $clog2(BMAX) : 1;

    localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_DATA = BW'(WIDTH_DATA - 1);
    localparam logic [BW-1:0] BIT_STOP = BW'(NB_STOP - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // input conditioning
    logic rx_meta_q, rx_sync_q;
    logic ck_meta_q, ck_sync_q;
    logic rxs, tick, sample;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            ck_meta_q <= 1'b0;
            ck_sync_q <= 1'b0;
        end else begin
            rx_meta_q <= bus.i_rx;
            rx_sync_q <= rx_meta_q;
            ck_meta_q <= bus.clk_rx;
            ck_sync_q <= ck_meta_q;
        end
    end

    assign rxs  = rx_sync_q;
    assign tick = ck_meta_q & ~ck_sync_q;

`ifdef RX_MAJORITY_EN
    // window = two previous tick values plus the current one
    logic [2:0] hist_q, hist_d;
    logic [2:0] win;

    assign win    = {hist_q[1:0], rxs};
    assign sample = (win[0] & win[1]) | (win[0] & win[2]) | (win[1] & win[2]);

    always_comb begin
        hist_d = hist_q;
        if (tick) hist_d = win;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) hist_q <= 3'b111;
        else       hist_q <= hist_d;
    end
`else
    assign sample = rxs;
`endif

    // frame FSM
    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BW-1:0]         bitcnt_q, bitcnt_d;
    logic [WIDTH_DATA-1:0] sipo_q, sipo_d;
    logic                  ferr_q, ferr_d;
    logic                  armed_q, armed_d;
    logic                  commit_q, commit_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bitcnt_d = bitcnt_q;
        sipo_d   = sipo_q;
        ferr_d   = ferr_q;
        armed_d  = armed_q;
        commit_d = 1'b0;
        if (tick) begin
            if (rxs) armed_d = 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (!rxs && armed_q) begin
                        state_d = S_START;
                        cnt_d   = '0;
                    end
                end
                S_START: begin
                    if (cnt_q == CNT_HALF) begin
                        if (sample) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d  = S_DATA;
                            cnt_d    = '0;
                            bitcnt_d = '0;
                            ferr_d   = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        sipo_d = {sample, sipo_q[WIDTH_DATA-1:1]};
                        cnt_d  = '0;
                        if (bitcnt_q == BIT_DATA) begin
                            state_d  = S_STOP;
                            bitcnt_d = '0;
                        end else begin
                            bitcnt_d = bitcnt_q + BW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d  = '0;
                        ferr_d = ferr_q | ~sample;
                        if (bitcnt_q == BIT_STOP) begin
                            // commit at mid-bit; a bad frame disarms until the line is seen high
                            state_d  = S_IDLE;
                            commit_d = 1'b1;
                            armed_d  = ~(ferr_q | ~sample);
                        end else begin
                            bitcnt_d = bitcnt_q + BW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bitcnt_q <= '0;
            sipo_q   <= '0;
            ferr_q   <= 1'b0;
            armed_q  <= 1'b1;
            commit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitcnt_q <= bitcnt_d;
            sipo_q   <= sipo_d;
            ferr_q   <= ferr_d;
            armed_q  <= armed_d;
            commit_q <= commit_d;
        end
    end

    // output holding register and read handshake
    logic [WIDTH_DATA-1:0] data_q, data_d;
    logic                  rdy_q, rdy_d;
    logic                  oferr_q, oferr_d;
    logic                  ovr_q, ovr_d;
    logic                  rd;

    assign rd = bus.i_re & rdy_q;

    always_comb begin
        data_d  = data_q;
        rdy_d   = rdy_q;
        oferr_d = oferr_q;
        ovr_d   = ovr_q;
        if (commit_q) begin
            if (!rdy_q || bus.i_re) begin
                data_d  = sipo_q;
                oferr_d = ferr_q;
                rdy_d   = 1'b1;
                if (rd) ovr_d = 1'b0;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (rd) begin
            rdy_d   = 1'b0;
            oferr_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            data_q  <= '0;
            rdy_q   <= 1'b0;
            oferr_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            rdy_q   <= rdy_d;
            oferr_q <= oferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.o_data = data_q;
    assign bus.o_rdy  = rdy_q;
    assign bus.o_ferr = oferr_q;
    assign bus.o_ovr  = ovr_q;
endmodule

// File: tb/tb_rx.sv
// Bench for rx: directed frames from the test plan plus random frames against a frame-level model.
module tb_rx;
    localparam int W    = 8;
    localparam int NB   = 2;
    localparam int OS   = 16;
    localparam int FLEN = OS * (1 + W + NB);
    // the tick seeing the last stop mid-sample lands one clk_rx period after it is driven
    localparam int COMMIT_IDX = OS / 2 + OS * (W + NB) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    logic [W-1:0] m_data;
    logic         m_rdy, m_ferr, m_ovr;

    rx_if #(.WIDTH_DATA(W)) bus ();

    rx #(.WIDTH_DATA(W), .NB_STOP(NB), .OVERSAMPLE(OS)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".rdy"}, 32'(bus.o_rdy), 32'(m_rdy));
        chk({tag, ".ovr"}, 32'(bus.o_ovr), 32'(m_ovr));
        if (m_rdy) begin
            chk({tag, ".data"}, 32'(bus.o_data), 32'(m_data));
            chk({tag, ".ferr"}, 32'(bus.o_ferr), 32'(m_ferr));
        end
    endtask

    // one clk_rx period carrying line value v; optional read strobe placed on the commit cycle slot
    task automatic drive(input logic v, input logic re);
        @(negedge clk); bus.clk_rx = 1'b1; bus.i_rx = v;
        @(negedge clk);
        @(negedge clk); bus.i_re = re;
        @(negedge clk); bus.i_re = 1'b0; bus.clk_rx = 1'b0;
    endtask

    function automatic void mdl_frame(input logic [W-1:0] d, input logic fe, input logic re);
        if (re && m_rdy) begin m_rdy = 1'b0; m_ovr = 1'b0; end
        if (!m_rdy) begin m_data = d; m_ferr = fe; m_rdy = 1'b1; end
        else m_ovr = 1'b1;
    endfunction

    task automatic do_read();
        drive(1'b1, 1'b1);
        if (m_rdy) begin m_rdy = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0; end
    endtask

    // glitch: index forced low; re_idx: period with i_re on commit; rst_idx: abort with reset
    task automatic send_frame(input logic [W-1:0] d, input logic [NB-1:0] bad,
                              input int glitch, input int re_idx, input int rst_idx);
        for (int i = 0; i < FLEN; i++) begin
            logic v;
            if (i < OS)                v = 1'b0;
            else if (i < OS * (1 + W)) v = d[(i - OS) / OS];
            else                       v = ~bad[(i - OS * (1 + W)) / OS];
            if (i == glitch) v = 1'b0;
            if (i == rst_idx) begin
                @(negedge clk); rst = 1'b1;
                #1;
                chk("rst_mid.data", 32'(bus.o_data), 0);
                chk("rst_mid.rdy",  32'(bus.o_rdy), 0);
                chk("rst_mid.ferr", 32'(bus.o_ferr), 0);
                chk("rst_mid.ovr",  32'(bus.o_ovr), 0);
                m_rdy = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0; m_data = '0;
                @(negedge clk); @(negedge clk);
                rst = 1'b0; bus.i_rx = 1'b1; bus.clk_rx = 1'b0; bus.i_re = 1'b0;
                return;
            end
            drive(v, 1'(i == re_idx));
        end
        repeat (4) drive(1'b1, 1'b0);
    endtask

    initial begin
        logic [W-1:0]  d;
        logic [NB-1:0] bad;
        logic          re_c;
        bus.clk_rx = 1'b0; bus.i_rx = 1'b1; bus.i_re = 1'b0;
        m_data = '0; m_rdy = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset.data", 32'(bus.o_data), 0);
        chk("reset.rdy",  32'(bus.o_rdy), 0);
        chk("reset.ferr", 32'(bus.o_ferr), 0);
        chk("reset.ovr",  32'(bus.o_ovr), 0);
        rst = 1'b0;
        repeat (8) drive(1'b1, 1'b0);

        send_frame(8'hA5, '0, -1, -1, -1); mdl_frame(8'hA5, 1'b0, 1'b0);
        chk_all("a5");
        do_read(); chk_all("a5_read");

        repeat (5) drive(1'b0, 1'b0);
        repeat (30) drive(1'b1, 1'b0);
        chk("glitch5.rdy", 32'(bus.o_rdy), 0);
        send_frame(8'h3C, '0, -1, -1, -1); mdl_frame(8'h3C, 1'b0, 1'b0);
        chk_all("3c");
        do_read();

        send_frame(8'h81, 2'b10, -1, -1, -1); mdl_frame(8'h81, 1'b1, 1'b0);
        chk_all("81_ferr");
        do_read();
        repeat (3 * FLEN) drive(1'b0, 1'b0);
        repeat (20) drive(1'b1, 1'b0);
        mdl_frame('0, 1'b1, 1'b0);
        chk_all("break");
        do_read(); chk_all("break_read");

        send_frame(8'h11, '0, -1, -1, -1); mdl_frame(8'h11, 1'b0, 1'b0);
        send_frame(8'h22, '0, -1, -1, -1); mdl_frame(8'h22, 1'b0, 1'b0);
        chk_all("ovr");
        do_read(); chk_all("ovr_read");
        send_frame(8'h11, '0, -1, -1, -1);         mdl_frame(8'h11, 1'b0, 1'b0);
        send_frame(8'h33, '0, -1, -1, -1);         mdl_frame(8'h33, 1'b0, 1'b0);
        send_frame(8'h22, '0, -1, COMMIT_IDX, -1); mdl_frame(8'h22, 1'b0, 1'b1);
        chk_all("re_commit");
        do_read();

        send_frame(8'h66, '0, -1, -1, -1); mdl_frame(8'h66, 1'b0, 1'b0);
        send_frame(8'hFF, '0, -1, -1, OS * 5 + 5);
        repeat (20) drive(1'b1, 1'b0);
        chk_all("after_rst");
        send_frame(8'h5A, '0, -1, -1, -1); mdl_frame(8'h5A, 1'b0, 1'b0);
        chk_all("5a");
        do_read();

        send_frame(8'hFF, '0, OS * 3 + OS / 2, -1, -1);
`ifdef RX_MAJORITY_EN
        mdl_frame(8'hFF, 1'b0, 1'b0);
`else
        mdl_frame(8'hFB, 1'b0, 1'b0);
`endif
        chk_all("glitch_bit2");
        do_read();

        for (int n = 0; n < 30; n++) begin
            d    = W'($urandom);
            bad  = ($urandom_range(0, 3) == 0) ? NB'($urandom_range(1, 3)) : '0;
            re_c = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) do_read();
            send_frame(d, bad, -1, re_c ? COMMIT_IDX : -1, -1);
            mdl_frame(d, |bad, re_c);
            chk_all("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
